depth_buffer_responder: RTL and testbench
=========================================

DEPTH_BUFFER_RESPONDER -- requirements
Module: depth_buffer_responder

Interface
REQ-001 The block SHALL have a parameter ADDR_WORDS_LOG2, default 10, giving log2 of the internal word count (1024 x 32-bit words).
REQ-002 The block SHALL have a parameter READ_LATENCY, default 2, legal range 1..4, giving the cycles from read acceptance to readdatavalid.
REQ-003 The block SHALL have a parameter CLEAR_VALUE, default 32'hFFFF_FFFF, giving the word written by the clear engine.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 slave_address  in  26  byte address; word index = slave_address[ADDR_WORDS_LOG2+1:2]; upper bits ignored (aliasing).
REQ-007 slave_read  in  1  read command.
REQ-008 slave_write  in  1  write command.
REQ-009 slave_byteenable  in  4  per-byte write enable; ignored for reads.
REQ-010 slave_writedata  in  32  write data.
REQ-011 slave_waitrequest  out  1  command not accepted this cycle.
REQ-012 slave_readdata  out  32  read response data.
REQ-013 slave_readdatavalid  out  1  one-cycle pulse per accepted read.
REQ-014 clear_start  in  1  single-cycle request to fill the whole array with CLEAR_VALUE.
REQ-015 clear_busy  out  1  clear engine active.
REQ-016 clear_done  out  1  one-cycle pulse when the clear completes.

Function
REQ-017 A command SHALL be accepted in any cycle where (slave_read or slave_write) is high and slave_waitrequest is low.
REQ-018 slave_waitrequest SHALL be a combinational function of state only: high in S_CLEAR, low in S_IDLE.
REQ-019 An accepted write SHALL update only the bytes whose slave_byteenable bit is set, visible to any read accepted in the following cycle or later.
REQ-020 An accepted read SHALL sample the array at acceptance and raise slave_readdatavalid exactly READ_LATENCY cycles later, with slave_readdata holding the full word.
REQ-021 Back-to-back reads SHALL be accepted every cycle; responses SHALL return in acceptance order, one per cycle, with no bubbles inserted.
REQ-022 When read and write are both high in an accepted cycle, the write SHALL be performed, the read SHALL be dropped, and no response SHALL be generated.
REQ-023 slave_readdata SHALL hold its last value when slave_readdatavalid is low.
REQ-024 The state machine SHALL have states S_IDLE and S_CLEAR; clear_start high in S_IDLE SHALL move to S_CLEAR next cycle with the word counter at 0.
REQ-025 In S_CLEAR, the block SHALL write CLEAR_VALUE to word counter, increment the counter every cycle, and after word 2^ADDR_WORDS_LOG2-1 return to S_IDLE with clear_done pulsed in that same transition cycle.
REQ-026 A clear SHALL take exactly 2^ADDR_WORDS_LOG2 cycles in S_CLEAR; clear_busy SHALL equal (state == S_CLEAR).
REQ-027 clear_start while in S_CLEAR SHALL be ignored.
REQ-028 A command presented in the same cycle as clear_start in S_IDLE SHALL be accepted and completed normally; its write lands before the clear overwrites it.
REQ-029 Reads accepted before the clear SHALL still return their pre-clear data on schedule while the clear runs.

Reset
REQ-030 On reset low, the block SHALL go to S_IDLE, clear the read pipeline valids, and drive slave_readdatavalid=0, slave_readdata=0, clear_busy=0, clear_done=0, word counter=0.
REQ-031 Reset SHALL not initialise the array; reset mid-clear SHALL abort the clear, leaving the array partially cleared.
REQ-032 Reads in flight at reset SHALL be discarded and produce no response.

Configuration
REQ-033 With macro DEPTH_BUFFER_CLEAR_EN defined, the clear engine SHALL be built as in REQ-024..029.
REQ-034 Without DEPTH_BUFFER_CLEAR_EN, clear_start SHALL be ignored, clear_busy and clear_done SHALL be tied 0, and slave_waitrequest SHALL be tied 0.

Verification
REQ-035 Write 0x12345678 to byte addr 0x40 (be=4'hF), next cycle read 0x40 -> readdatavalid exactly 2 cycles after acceptance, data 0x12345678.
REQ-036 Write 0xAABBCCDD to 0x40 with be=4'b0011 over 0x12345678 -> read returns 0x1234CCDD.
REQ-037 Eight consecutive reads of addrs 0x0..0x1C pre-loaded with 1..8 -> eight consecutive valid pulses, data 1..8 in order.
REQ-038 clear_start with DEPTH_BUFFER_CLEAR_EN -> waitrequest high for exactly 1024 cycles, clear_done one pulse, all reads return 0xFFFFFFFF.
REQ-039 Read and write both high to 0x80 with data 0x5 -> no readdatavalid; subsequent read of 0x80 returns 0x5.
REQ-040 Reset asserted 3 cycles into a clear, with one read in flight -> no readdatavalid, clear_busy 0, waitrequest 0 after release.

Source files
------------

// File: rtl/depth_buffer_responder.sv
// Word-addressed 32-bit buffer with pipelined read responses and an optional clear engine.
// Define DEPTH_BUFFER_CLEAR_EN to build the clear engine; without it clear_start is ignored.
module depth_buffer_responder #(
  parameter int          ADDR_WORDS_LOG2 = 10,
  parameter int          READ_LATENCY    = 2,
  parameter logic [31:0] CLEAR_VALUE     = 32'hFFFF_FFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [25:0] slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [3:0]  slave_byteenable,
  input  logic [31:0] slave_writedata,
  output logic        slave_waitrequest,
  output logic [31:0] slave_readdata,
  output logic        slave_readdatavalid,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done
);

  localparam int WORDS = 2 ** ADDR_WORDS_LOG2;

  logic [31:0]                mem_r [WORDS];
  logic [ADDR_WORDS_LOG2-1:0] idx_s;
  logic [ADDR_WORDS_LOG2-1:0] clr_addr_s;
  logic                       cmd_acc_s;
  logic                       wr_acc_s;
  logic                       rd_acc_s;
  logic                       clr_we_s;
  logic                       vld_r [READ_LATENCY];
  logic [31:0]                dat_r [READ_LATENCY];
  logic                       unused_s;

  assign idx_s     = slave_address[ADDR_WORDS_LOG2+1:2];
  assign cmd_acc_s = (slave_read | slave_write) & ~slave_waitrequest;
  assign wr_acc_s  = cmd_acc_s & slave_write;
  // A read paired with a write is dropped, so it never enters the pipeline.
  assign rd_acc_s  = cmd_acc_s & slave_read & ~slave_write;

`ifdef DEPTH_BUFFER_CLEAR_EN
  typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_WORDS_LOG2-1:0] CNT_LAST = {ADDR_WORDS_LOG2{1'b1}};
  localparam logic [ADDR_WORDS_LOG2-1:0] CNT_ONE  = {{(ADDR_WORDS_LOG2-1){1'b0}}, 1'b1};

  state_t                     state_r;
  state_t                     next_state_s;
  logic [ADDR_WORDS_LOG2-1:0] clr_cnt_r;
  logic [ADDR_WORDS_LOG2-1:0] cnt_next_s;
  logic                       clear_done_r;
  logic                       done_next_s;

  // Clear engine state, word counter and done pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      clr_cnt_r    <= {ADDR_WORDS_LOG2{1'b0}};
      clear_done_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      clr_cnt_r    <= cnt_next_s;
      clear_done_r <= done_next_s;
    end
  end

  // Clear engine next-state logic: walk every word once, then pulse done.
  always_comb begin
    next_state_s = state_r;
    cnt_next_s   = clr_cnt_r;
    done_next_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (clear_start) begin
          next_state_s = S_CLEAR;
          cnt_next_s   = {ADDR_WORDS_LOG2{1'b0}};
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_next_s = clr_cnt_r + CNT_ONE;
        if (clr_cnt_r == CNT_LAST) begin
          next_state_s = S_IDLE;
          done_next_s  = 1'b1;
        end else begin
          next_state_s = S_CLEAR;
        end
      end
      default: begin
        next_state_s = S_IDLE;
        cnt_next_s   = {ADDR_WORDS_LOG2{1'b0}};
      end
    endcase
  end

  assign slave_waitrequest = (state_r == S_CLEAR);
  assign clear_busy        = (state_r == S_CLEAR);
  assign clr_we_s          = (state_r == S_CLEAR);
  assign clr_addr_s        = clr_cnt_r;
  assign clear_done        = clear_done_r;
  assign unused_s          = ^{slave_address[25:ADDR_WORDS_LOG2+2], slave_address[1:0]};
`else
  assign slave_waitrequest = 1'b0;
  assign clear_busy        = 1'b0;
  assign clear_done        = 1'b0;
  assign clr_we_s          = 1'b0;
  assign clr_addr_s        = {ADDR_WORDS_LOG2{1'b0}};
  assign unused_s          = ^{slave_address[25:ADDR_WORDS_LOG2+2], slave_address[1:0], clear_start};
`endif

  // Array writes; host commands are stalled while the clear engine owns the array.
  always_ff @(posedge clock) begin
    if (clr_we_s) begin
      mem_r[clr_addr_s] <= CLEAR_VALUE;
    end else if (wr_acc_s) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_byteenable[b]) begin
          mem_r[idx_s][8*b +: 8] <= slave_writedata[8*b +: 8];
        end
      end
    end
  end

  // Read response pipeline; data stages only load behind a valid so the output holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        vld_r[i] <= 1'b0;
        dat_r[i] <= 32'h0000_0000;
      end
    end else begin
      vld_r[0] <= rd_acc_s;
      if (rd_acc_s) begin
        dat_r[0] <= mem_r[idx_s];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        if (vld_r[i-1]) begin
          dat_r[i] <= dat_r[i-1];
        end
      end
    end
  end

  assign slave_readdatavalid = vld_r[READ_LATENCY-1];
  assign slave_readdata      = dat_r[READ_LATENCY-1];

endmodule

// File: tb/tb_depth_buffer_responder.sv
// Randomised self-checking bench for depth_buffer_responder against a queue-based reference model.
// Clear-engine scenarios are exercised when DEPTH_BUFFER_CLEAR_EN is defined.
module tb_depth_buffer_responder;

  localparam int L  = 2;
  localparam int NW = 1024;
`ifdef DEPTH_BUFFER_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [25:0] slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [3:0]  slave_byteenable;
  logic [31:0] slave_writedata;
  logic        slave_waitrequest;
  logic [31:0] slave_readdata;
  logic        slave_readdatavalid;
  logic        clear_start;
  logic        clear_busy;
  logic        clear_done;

  depth_buffer_responder #(
    .ADDR_WORDS_LOG2(10),
    .READ_LATENCY(L),
    .CLEAR_VALUE(32'hFFFF_FFFF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .slave_address(slave_address),
    .slave_read(slave_read),
    .slave_write(slave_write),
    .slave_byteenable(slave_byteenable),
    .slave_writedata(slave_writedata),
    .slave_waitrequest(slave_waitrequest),
    .slave_readdata(slave_readdata),
    .slave_readdatavalid(slave_readdatavalid),
    .clear_start(clear_start),
    .clear_busy(clear_busy),
    .clear_done(clear_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] mem_m [NW];
  rsp_t        rq [$];
  int          cyc;
  int          clr_left;
  bit          done_exp;
  logic [31:0] last_data;
  int          tests;
  int          fails;
  int          busy_seen;
  int          wait_seen;
  int          done_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge: update the model from the inputs presented, then compare all outputs.
  task automatic cycle();
    bit   acc;
    int   idx;
    rsp_t r;
    acc = reset && (slave_read || slave_write) && (clr_left == 0);
    idx = int'(slave_address[11:2]);
    @(posedge clock);
    if (acc) begin
      if (slave_write) begin
        for (int b = 0; b < 4; b++)
          if (slave_byteenable[b]) mem_m[idx][8*b +: 8] = slave_writedata[8*b +: 8];
      end else begin
        r.due  = cyc + L;
        r.data = mem_m[idx];
        rq.push_back(r);
      end
    end
    done_exp = 1'b0;
    if (reset) begin
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) begin
          done_exp = 1'b1;
          for (int i = 0; i < NW; i++) mem_m[i] = 32'hFFFF_FFFF;
        end
      end else if (clear_start && CLR_EN) begin
        clr_left = NW;
      end
    end
    cyc++;
    #1;
    busy_seen += int'(clear_busy);
    wait_seen += int'(slave_waitrequest);
    done_seen += int'(clear_done);
    check_eq("waitrequest", 32'(slave_waitrequest), 32'(clr_left > 0));
    check_eq("clear_busy", 32'(clear_busy), 32'(clr_left > 0));
    check_eq("clear_done", 32'(clear_done), 32'(done_exp));
    if (rq.size() > 0 && rq[0].due == cyc) begin
      check_eq("rvalid", 32'(slave_readdatavalid), 32'd1);
      check_eq("rdata", slave_readdata, rq[0].data);
      last_data = rq[0].data;
      void'(rq.pop_front());
    end else begin
      check_eq("rvalid_idle", 32'(slave_readdatavalid), 32'd0);
      check_eq("rdata_hold", slave_readdata, last_data);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [25:0] a,
                       input logic [3:0] be, input logic [31:0] d, input bit cs);
    slave_read       = rd;
    slave_write      = wr;
    slave_address    = a;
    slave_byteenable = be;
    slave_writedata  = d;
    clear_start      = cs;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 26'h0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    slave_read  = 1'b0;
    slave_write = 1'b0;
    clear_start = 1'b0;
    reset       = 1'b0;
    rq.delete();
    clr_left  = 0;
    last_data = 32'h0;
    #1;
    check_eq("rst_rvalid", 32'(slave_readdatavalid), 32'd0);
    check_eq("rst_rdata", slave_readdata, 32'h0);
    check_eq("rst_busy", 32'(clear_busy), 32'd0);
    check_eq("rst_done", 32'(clear_done), 32'd0);
    check_eq("rst_wait", 32'(slave_waitrequest), 32'd0);
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic fill_region();
    for (int w = 0; w < 16; w++) drive(1'b0, 1'b1, 26'(w * 4), 4'hF, $urandom(), 1'b0);
  endtask

  task automatic random_run(input int n);
    logic [13:0] up;
    logic [3:0]  w;
    logic [1:0]  lo;
    int          op;
    for (int i = 0; i < n; i++) begin
      up = 14'($urandom());
      w  = 4'($urandom_range(0, 15));
      lo = 2'($urandom());
      op = $urandom_range(0, 3);
      drive(op == 1 || op == 3, op >= 2, {up, 6'h00, w, lo}, 4'($urandom()), $urandom(), 1'b0);
    end
  endtask

  initial begin
    slave_address    = 26'h0;
    slave_read       = 1'b0;
    slave_write      = 1'b0;
    slave_byteenable = 4'h0;
    slave_writedata  = 32'h0;
    clear_start      = 1'b0;
    cyc = 0; tests = 0; fails = 0; clr_left = 0; last_data = 32'h0;
    for (int i = 0; i < NW; i++) mem_m[i] = 32'h0;
    #2;
    do_reset();

    // Full write then read; partial-byte overwrite then read.
    drive(1'b0, 1'b1, 26'h40, 4'hF, 32'h1234_5678, 1'b0);
    drive(1'b1, 1'b0, 26'h40, 4'h0, 32'h0, 1'b0);
    idle(4);
    drive(1'b0, 1'b1, 26'h40, 4'b0011, 32'hAABB_CCDD, 1'b0);
    drive(1'b1, 1'b0, 26'h40, 4'h0, 32'h0, 1'b0);
    idle(4);
    check_eq("partial_write_model", mem_m[16], 32'h1234_CCDD);

    // Eight back-to-back reads.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 26'(i * 4), 4'hF, 32'(i + 1), 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 26'(i * 4), 4'h0, 32'h0, 1'b0);
    idle(4);

    // Simultaneous read and write: write wins, no response.
    drive(1'b1, 1'b1, 26'h80, 4'hF, 32'h5, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 26'h80, 4'h0, 32'h0, 1'b0);
    idle(4);

    fill_region();
    random_run(600);
    idle(4);

    // Clear: a read before, a write alongside clear_start, stray traffic while busy.
    busy_seen = 0; wait_seen = 0; done_seen = 0;
    drive(1'b1, 1'b0, 26'h04, 4'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 26'h100, 4'hF, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < NW + 6; i++)
      drive(1'($urandom()), 1'($urandom()), 26'($urandom_range(0, 63) * 4), 4'hF, $urandom(),
            (i % 97) == 5);
    clear_start = 1'b0;
    check_eq("clear_busy_cycles", 32'(busy_seen), CLR_EN ? 32'd1024 : 32'd0);
    check_eq("clear_wait_cycles", 32'(wait_seen), CLR_EN ? 32'd1024 : 32'd0);
    check_eq("clear_done_pulses", 32'(done_seen), CLR_EN ? 32'd1 : 32'd0);
    drive(1'b1, 1'b0, 26'h100, 4'h0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b0, 26'($urandom_range(0, NW - 1) * 4), 4'h0, 32'h0, 1'b0);
    idle(4);

    // Reset three cycles into a clear.
    drive(1'b0, 1'b0, 26'h0, 4'h0, 32'h0, 1'b1);
    idle(3);
    do_reset();
    idle(3);

    // Reset with a read in flight (also starts a clear when the engine is built).
    fill_region();
    drive(1'b1, 1'b0, 26'h08, 4'h0, 32'h0, 1'b1);
    do_reset();
    idle(4);

    fill_region();
    random_run(300);
    idle(6);
    check_eq("rsp_queue_drained", 32'(rq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
